dpram_port_arbiter: RTL and testbench
=====================================

DPRAM_PORT_ARBITER -- requirements
Module: dpram_port_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter ADDR, default 2: address width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_a / req_b  input  1  requester A/B command request; held with its command fields stable until the matching gnt.
REQ-006 we_a / we_b  input  1  command type: 1 = write, 0 = read.
REQ-007 addr_a / addr_b  input  ADDR  command address.
REQ-008 wdata_a / wdata_b  input  WIDTH  write data.
REQ-009 gnt_a / gnt_b  output  1  one-cycle pulse: command accepted this cycle.
REQ-010 rvalid_a / rvalid_b  output  1  one-cycle pulse: rdata_a/rdata_b holds read result.
REQ-011 rdata_a / rdata_b  output  WIDTH  read result, held until next rvalid.
REQ-012 ram_cs_p0/p1, ram_wr_rd_p0/p1, ram_oe_p0/p1  output  1 each  RAM port 0/1 chip select, write enable, output enable.
REQ-013 ram_addr_p0/p1  output  ADDR  RAM port address.
REQ-014 ram_wdata_p0/p1  output  WIDTH  data driven onto RAM bus; ram_drv_p0/p1 output 1 = drive enable for external tristate.
REQ-015 ram_rdata_p0/p1  input  WIDTH  RAM bus sampled value.

Function
REQ-016 Requester A SHALL own RAM port 0; requester B SHALL own RAM port 1.
REQ-017 Each port SHALL run an FSM with states IDLE, WRITE, READ, RDATA; all RAM outputs registered from FSM state.
REQ-018 A gnt SHALL issue only when req is high, port state is IDLE, WRITE or RDATA, and no collision loss (REQ-023); never in READ.
REQ-019 On gnt in cycle T, addr/we/wdata SHALL be registered; next state WRITE if we=1 else READ.
REQ-020 WRITE (cycle T+1): cs=1, wr_rd=1, oe=0, drv=1, addr, wdata driven; RAM stores at end of T+1; next state IDLE unless another gnt in T+1 (back-to-back writes, 1 per cycle).
REQ-021 READ (T+1): cs=1, wr_rd=0, oe=0, drv=0; next state RDATA unconditionally.
REQ-022 RDATA (T+2): cs=1, oe=1, wr_rd=0, drv=0; ram_rdata captured into rdata at end of T+2; rvalid=1 in T+3; read latency gnt-to-rvalid = 3 cycles.
REQ-023 Collision: req_a and req_b both high, both grantable, addr_a==addr_b, and we_a|we_b=1 -> only the side holding priority SHALL be granted; loser retries next cycle.
REQ-024 Priority bit SHALL reset to A and toggle only after a collision is resolved in its holder's favour (round-robin).
REQ-025 Same-address read/read, or different addresses, SHALL grant both in the same cycle.
REQ-026 In IDLE all RAM controls SHALL be 0 (wr_rd=0 and drv=0 guarantee no spurious write).
REQ-027 wr_rd=1 and oe=1 SHALL never be asserted together on a port; drv=1 only in WRITE.
REQ-028 A gnt in RDATA SHALL not alter that cycle's capture or the following rvalid.

Reset
REQ-029 On rst=1 at a clock edge: both FSMs IDLE, priority=A, all RAM controls, gnt, rvalid, rdata=0 after that edge.
REQ-030 Reset mid-operation SHALL abandon in-flight commands: no pending write completes after the edge, no rvalid for an aborted read.
REQ-031 gnt SHALL be 0 in any cycle where rst=1.

Verification
REQ-032 A writes addr 1 = 0x5A, then A reads addr 1 -> gnt_a each; rvalid_a 3 cycles after read gnt, rdata_a=0x5A.
REQ-033 A and B both write addr 2 same cycle (0x11, 0x22), after reset -> gnt_a first, gnt_b next cycle; later read addr 2 returns 0x22; repeat collision -> B wins first.
REQ-034 A writes addr 0, B reads addr 3 same cycle -> both granted that cycle; no stall.
REQ-035 A issues read, holds req_a with a write -> no gnt_a in READ cycle; gnt_a in RDATA cycle; wr_rd_p0 and oe_p0 never both 1.
REQ-036 rst asserted in READ state -> next cycle all outputs 0, no rvalid_a ever for that read.
REQ-037 A writes addrs 0..3 back-to-back -> four consecutive gnt_a, four consecutive WRITE cycles, all readbacks correct.

Source files
------------

// File: rtl/dpram_port_arbiter.sv
// rtl/dpram_port_arbiter.sv - two-requester arbiter driving the two ports of a dual-port RAM
// Each requester owns one RAM port; same-address conflicts involving a write are settled round-robin.
module dpram_port_arbiter #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             we_a,
    input  logic [ADDR-1:0]  addr_a,
    input  logic [WIDTH-1:0] wdata_a,
    input  logic             req_b,
    input  logic             we_b,
    input  logic [ADDR-1:0]  addr_b,
    input  logic [WIDTH-1:0] wdata_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             rvalid_a,
    output logic             rvalid_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             ram_cs_p0,
    output logic             ram_cs_p1,
    output logic             ram_wr_rd_p0,
    output logic             ram_wr_rd_p1,
    output logic             ram_oe_p0,
    output logic             ram_oe_p1,
    output logic [ADDR-1:0]  ram_addr_p0,
    output logic [ADDR-1:0]  ram_addr_p1,
    output logic [WIDTH-1:0] ram_wdata_p0,
    output logic [WIDTH-1:0] ram_wdata_p1,
    output logic             ram_drv_p0,
    output logic             ram_drv_p1,
    input  logic [WIDTH-1:0] ram_rdata_p0,
    input  logic [WIDTH-1:0] ram_rdata_p1
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RDATA} state_t;

    state_t           state_q [2];
    state_t           state_d [2];
    logic             cs_q [2], cs_d [2];
    logic             wr_q [2], wr_d [2];
    logic             oe_q [2], oe_d [2];
    logic             drv_q [2], drv_d [2];
    logic [ADDR-1:0]  addr_q [2], addr_d [2];
    logic [WIDTH-1:0] wdata_q [2], wdata_d [2];
    logic             rvalid_q [2], rvalid_d [2];
    logic [WIDTH-1:0] rdata_q [2], rdata_d [2];
    logic             prio_q, prio_d;

    logic             req [2];
    logic             we [2];
    logic [ADDR-1:0]  addr [2];
    logic [WIDTH-1:0] wdata [2];
    logic [WIDTH-1:0] ram_rdata [2];
    logic             grantable [2];
    logic             gnt [2];
    logic             collide;

    assign req[0]       = req_a;
    assign req[1]       = req_b;
    assign we[0]        = we_a;
    assign we[1]        = we_b;
    assign addr[0]      = addr_a;
    assign addr[1]      = addr_b;
    assign wdata[0]     = wdata_a;
    assign wdata[1]     = wdata_b;
    assign ram_rdata[0] = ram_rdata_p0;
    assign ram_rdata[1] = ram_rdata_p1;

    // prio_q: 0 = A holds priority, 1 = B holds priority
    always_comb begin
        prio_d = prio_q;
        for (int i = 0; i < 2; i++) begin
            grantable[i] = req[i] && (state_q[i] != READ);
        end
        collide = grantable[0] && grantable[1] && (addr[0] == addr[1]) && (we[0] || we[1]);
        gnt[0]  = !rst && grantable[0] && !(collide && prio_q);
        gnt[1]  = !rst && grantable[1] && !(collide && !prio_q);
        if (collide) begin
            prio_d = ~prio_q;
        end

        for (int i = 0; i < 2; i++) begin
            state_d[i] = IDLE;
            if (gnt[i]) begin
                state_d[i] = we[i] ? WRITE : READ;
            end else if (state_q[i] == READ) begin
                state_d[i] = RDATA;
            end

            cs_d[i]  = (state_d[i] != IDLE);
            wr_d[i]  = (state_d[i] == WRITE);
            oe_d[i]  = (state_d[i] == RDATA);
            drv_d[i] = (state_d[i] == WRITE);

            // Address stays on the bus from READ through RDATA; the bus idles at zero otherwise.
            addr_d[i] = '0;
            if (gnt[i]) begin
                addr_d[i] = addr[i];
            end else if (state_d[i] == RDATA) begin
                addr_d[i] = addr_q[i];
            end
            wdata_d[i] = (gnt[i] && we[i]) ? wdata[i] : '0;

            rvalid_d[i] = (state_q[i] == RDATA);
            rdata_d[i]  = (state_q[i] == RDATA) ? ram_rdata[i] : rdata_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                state_q[i]  <= IDLE;
                cs_q[i]     <= 1'b0;
                wr_q[i]     <= 1'b0;
                oe_q[i]     <= 1'b0;
                drv_q[i]    <= 1'b0;
                addr_q[i]   <= '0;
                wdata_q[i]  <= '0;
                rvalid_q[i] <= 1'b0;
                rdata_q[i]  <= '0;
            end
        end else begin
            prio_q <= prio_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i]  <= state_d[i];
                cs_q[i]     <= cs_d[i];
                wr_q[i]     <= wr_d[i];
                oe_q[i]     <= oe_d[i];
                drv_q[i]    <= drv_d[i];
                addr_q[i]   <= addr_d[i];
                wdata_q[i]  <= wdata_d[i];
                rvalid_q[i] <= rvalid_d[i];
                rdata_q[i]  <= rdata_d[i];
            end
        end
    end

    assign gnt_a        = gnt[0];
    assign gnt_b        = gnt[1];
    assign rvalid_a     = rvalid_q[0];
    assign rvalid_b     = rvalid_q[1];
    assign rdata_a      = rdata_q[0];
    assign rdata_b      = rdata_q[1];
    assign ram_cs_p0    = cs_q[0];
    assign ram_cs_p1    = cs_q[1];
    assign ram_wr_rd_p0 = wr_q[0];
    assign ram_wr_rd_p1 = wr_q[1];
    assign ram_oe_p0    = oe_q[0];
    assign ram_oe_p1    = oe_q[1];
    assign ram_addr_p0  = addr_q[0];
    assign ram_addr_p1  = addr_q[1];
    assign ram_wdata_p0 = wdata_q[0];
    assign ram_wdata_p1 = wdata_q[1];
    assign ram_drv_p0   = drv_q[0];
    assign ram_drv_p1   = drv_q[1];

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb/tb_dpram_port_arbiter.sv - directed table-driven bench for dpram_port_arbiter
// Includes a behavioural dual-port RAM so reads return what earlier writes stored.
module tb_dpram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [1:0] addr_a = '0, addr_b = '0;
    logic [7:0] wdata_a = '0, wdata_b = '0;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [7:0] rdata_a, rdata_b;
    logic       ram_cs_p0, ram_cs_p1, ram_wr_rd_p0, ram_wr_rd_p1, ram_oe_p0, ram_oe_p1;
    logic [1:0] ram_addr_p0, ram_addr_p1;
    logic [7:0] ram_wdata_p0, ram_wdata_p1;
    logic       ram_drv_p0, ram_drv_p1;
    logic [7:0] ram_rdata_p0, ram_rdata_p1;

    int errors = 0;
    int checks = 0;
    logic monitor_on = 1'b0;

    always #5 clk = ~clk;

    dpram_port_arbiter #(.WIDTH(8), .ADDR(2)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .ram_cs_p0(ram_cs_p0), .ram_cs_p1(ram_cs_p1),
        .ram_wr_rd_p0(ram_wr_rd_p0), .ram_wr_rd_p1(ram_wr_rd_p1),
        .ram_oe_p0(ram_oe_p0), .ram_oe_p1(ram_oe_p1),
        .ram_addr_p0(ram_addr_p0), .ram_addr_p1(ram_addr_p1),
        .ram_wdata_p0(ram_wdata_p0), .ram_wdata_p1(ram_wdata_p1),
        .ram_drv_p0(ram_drv_p0), .ram_drv_p1(ram_drv_p1),
        .ram_rdata_p0(ram_rdata_p0), .ram_rdata_p1(ram_rdata_p1)
    );

    logic [7:0] mem [4];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) mem[k] <= '0;
        end else begin
            if (ram_cs_p0 && ram_wr_rd_p0 && ram_drv_p0) mem[ram_addr_p0] <= ram_wdata_p0;
            if (ram_cs_p1 && ram_wr_rd_p1 && ram_drv_p1) mem[ram_addr_p1] <= ram_wdata_p1;
        end
    end
    assign ram_rdata_p0 = mem[ram_addr_p0];
    assign ram_rdata_p1 = mem[ram_addr_p1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (monitor_on) begin
            chk("port_exclusive", {ram_wr_rd_p0 & ram_oe_p0, ram_wr_rd_p1 & ram_oe_p1,
                                   ram_drv_p0 ^ ram_wr_rd_p0, ram_drv_p1 ^ ram_wr_rd_p1}, 32'h0);
        end
    end

    typedef struct {
        logic       rst;
        logic       ra, wa;
        logic [1:0] aa;
        logic [7:0] da;
        logic       rb, wb;
        logic [1:0] ab;
        logic [7:0] db;
        logic       eg_a, eg_b, ev_a, ev_b;
        logic [7:0] ed_a, ed_b;
    } vec_t;

    localparam int NV = 26;
    vec_t v [NV];

    task automatic set_a(input int i, input logic wa, input logic [1:0] aa, input logic [7:0] da);
        v[i].ra = 1'b1; v[i].wa = wa; v[i].aa = aa; v[i].da = da;
    endtask
    task automatic set_b(input int i, input logic wb, input logic [1:0] ab, input logic [7:0] db);
        v[i].rb = 1'b1; v[i].wb = wb; v[i].ab = ab; v[i].db = db;
    endtask
    task automatic exp_g(input int i, input logic ga, input logic gb);
        v[i].eg_a = ga; v[i].eg_b = gb;
    endtask
    task automatic exp_va(input int i, input logic [7:0] d);
        v[i].ev_a = 1'b1; v[i].ed_a = d;
    endtask
    task automatic exp_vb(input int i, input logic [7:0] d);
        v[i].ev_b = 1'b1; v[i].ed_b = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic r, input logic w, input logic [1:0] a, input logic [7:0] d);
        req_a = r; we_a = w; addr_a = a; wdata_a = d;
    endtask

    initial begin
        for (int i = 0; i < NV; i++) begin
            v[i] = '{default: '0};
        end
        v[0].rst = 1'b1; set_a(0, 1, 2'd1, 8'h5A); set_b(0, 1, 2'd1, 8'h11);
        set_b(1, 1, 2'd3, 8'h3C);                     exp_g(1, 0, 1);
        set_a(2, 1, 2'd2, 8'h11); set_b(2, 1, 2'd2, 8'h22); exp_g(2, 1, 0);
        set_b(3, 1, 2'd2, 8'h22);                     exp_g(3, 0, 1);
        set_a(4, 1, 2'd1, 8'h5A);                     exp_g(4, 1, 0);
        set_a(5, 0, 2'd1, 8'h00);                     exp_g(5, 1, 0);
        set_a(6, 0, 2'd2, 8'h00);                     exp_g(6, 0, 0);
        set_a(7, 0, 2'd2, 8'h00);                     exp_g(7, 1, 0);
        exp_va(8, 8'h5A);
        set_a(10, 1, 2'd2, 8'h33); set_b(10, 1, 2'd2, 8'h44); exp_g(10, 0, 1); exp_va(10, 8'h22);
        set_a(11, 1, 2'd2, 8'h33);                    exp_g(11, 1, 0);
        set_a(12, 1, 2'd0, 8'h77); set_b(12, 0, 2'd3, 8'h00); exp_g(12, 1, 1);
        set_a(15, 0, 2'd2, 8'h00); exp_g(15, 1, 0); exp_vb(15, 8'h3C);
        set_a(18, 0, 2'd2, 8'h00); set_b(18, 0, 2'd2, 8'h00); exp_g(18, 1, 1); exp_va(18, 8'h33);
        exp_va(21, 8'h33); exp_vb(21, 8'h33);
        set_a(22, 0, 2'd0, 8'h00); exp_g(22, 1, 0);
        exp_va(25, 8'h77);

        tick();
        chk("reset_ctrl_p0", {ram_cs_p0, ram_wr_rd_p0, ram_oe_p0, ram_drv_p0}, 32'h0);
        chk("reset_ctrl_p1", {ram_cs_p1, ram_wr_rd_p1, ram_oe_p1, ram_drv_p1}, 32'h0);
        chk("reset_rd", {rvalid_a, rvalid_b, rdata_a, rdata_b}, 32'h0);
        monitor_on = 1'b1;

        for (int i = 0; i < NV; i++) begin
            rst = v[i].rst;
            req_a = v[i].ra; we_a = v[i].wa; addr_a = v[i].aa; wdata_a = v[i].da;
            req_b = v[i].rb; we_b = v[i].wb; addr_b = v[i].ab; wdata_b = v[i].db;
            #4;
            chk($sformatf("row%0d_gnt", i), {gnt_a, gnt_b}, {v[i].eg_a, v[i].eg_b});
            chk($sformatf("row%0d_rvalid", i), {rvalid_a, rvalid_b}, {v[i].ev_a, v[i].ev_b});
            if (v[i].ev_a) chk($sformatf("row%0d_rdata_a", i), rdata_a, v[i].ed_a);
            if (v[i].ev_b) chk($sformatf("row%0d_rdata_b", i), rdata_b, v[i].ed_b);
            tick();
        end
        req_a = 0; req_b = 0; rst = 0;
        tick();

        for (int i = 0; i < 4; i++) begin
            drive_a(1, 1, 2'(i), 8'hA0 + 8'(i));
            #4;
            chk($sformatf("b2b_gnt%0d", i), gnt_a, 1);
            if (i > 0) chk($sformatf("b2b_wr%0d", i), {ram_cs_p0, ram_wr_rd_p0, 6'(ram_addr_p0), ram_wdata_p0},
                           {1'b1, 1'b1, 6'(i - 1), 8'hA0 + 8'(i - 1)});
            tick();
        end
        drive_a(0, 0, 2'd0, 8'h00);
        #4;
        chk("b2b_wr3", {ram_cs_p0, ram_wr_rd_p0, 6'(ram_addr_p0), ram_wdata_p0}, {1'b1, 1'b1, 6'd3, 8'hA3});
        tick();
        #4;
        chk("b2b_idle", {ram_cs_p0, ram_wr_rd_p0, ram_drv_p0}, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive_a(1, 0, 2'(i), 8'h00);
            #4;
            chk($sformatf("rb_gnt%0d", i), gnt_a, 1);
            tick();
            drive_a(0, 0, 2'd0, 8'h00);
            tick();
            tick();
            #4;
            chk($sformatf("rb_data%0d", i), {rvalid_a, rdata_a}, {1'b1, 8'hA0 + 8'(i)});
            tick();
        end

        drive_a(1, 0, 2'd1, 8'h00);
        #4;
        chk("hold_gnt_idle", gnt_a, 1);
        tick();
        drive_a(1, 1, 2'd1, 8'h99);
        #4;
        chk("hold_no_gnt_read", {gnt_a, ram_cs_p0, ram_wr_rd_p0, ram_oe_p0}, 4'b0100);
        tick();
        #4;
        chk("hold_gnt_rdata", {gnt_a, ram_oe_p0, ram_wr_rd_p0}, 3'b110);
        tick();
        drive_a(0, 0, 2'd0, 8'h00);
        #4;
        chk("hold_rvalid", {rvalid_a, rdata_a}, {1'b1, 8'hA1});
        chk("hold_write", {ram_wr_rd_p0, ram_oe_p0, ram_wdata_p0}, {1'b1, 1'b0, 8'h99});
        tick();
        tick();

        drive_a(1, 0, 2'd0, 8'h00);
        #4;
        chk("rst_rd_gnt", gnt_a, 1);
        tick();
        rst = 1'b1;
        drive_a(1, 1, 2'd2, 8'h55);
        req_b = 1'b1; we_b = 1'b0; addr_b = 2'd3;
        #4;
        chk("rst_gnt_zero", {gnt_a, gnt_b}, 2'b00);
        tick();
        rst = 1'b0;
        drive_a(0, 0, 2'd0, 8'h00);
        req_b = 1'b0;
        #4;
        chk("rst_outs_p0", {ram_cs_p0, ram_wr_rd_p0, ram_oe_p0, ram_drv_p0, 6'(ram_addr_p0), ram_wdata_p0}, 32'h0);
        chk("rst_outs_rd", {rvalid_a, rvalid_b, rdata_a, rdata_b}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            #4;
            chk($sformatf("rst_no_rvalid%0d", i), rvalid_a, 0);
        end

        monitor_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
